// File: rtl/bss_serial_engine.sv
// Bit-serial transfer engine between HPS PIO words and the BSS serial bus.
// Toggle handshakes on ctl_in[0]/status_out[0]; all serial outputs are registered.
module bss_serial_engine #(
  parameter int N_OUT   = 9,
  parameter int N_IN    = 4,
  parameter int WORD_W  = 32,
  parameter int CLK_DIV = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              ctl_in,
  output logic [31:0]              status_out,
  input  logic [N_OUT*WORD_W-1:0]  tx_words,
  output logic [N_IN*WORD_W-1:0]   rx_words,
  output logic                     ser_sclk,
  output logic                     ser_latch,
  output logic [N_OUT-1:0]         ser_dout,
  input  logic [N_IN-1:0]          ser_din
);
  localparam int LW = $clog2(WORD_W + 1);
  localparam int IW = $clog2(WORD_W);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic                    r_go_seen, r_done_tgl, r_busy, r_overrun, r_msb;
  logic [7:0]              r_count;
  logic [LW-1:0]           r_len, r_bitcnt;
  logic [DW-1:0]           r_div;
  logic [WORD_W-1:0]       r_tx [N_OUT];
  logic [WORD_W-1:0]       r_rx [N_IN];
  logic                    r_sclk, r_latch;
  logic [N_OUT-1:0]        r_dout;
  logic [N_IN*WORD_W-1:0]  r_rx_words;

  logic [WORD_W-1:0]       w_tx_in [N_OUT];
  logic [7:0]              w_len_req;
  logic [LW-1:0]           w_len_eff;
  logic                    w_go_pending, w_div_end;
  logic [IW-1:0]           w_cur_idx, w_nxt_idx;
  logic                    w_unused_ok;

  assign w_len_req    = ctl_in[15:8];
  assign w_len_eff    = (w_len_req == 8'd0 || w_len_req > 8'(WORD_W)) ? LW'(WORD_W)
                                                                      : w_len_req[LW-1:0];
  assign w_go_pending = (ctl_in[0] != r_go_seen);
  assign w_div_end    = (r_div == DW'(CLK_DIV - 1));
  assign w_unused_ok  = ^{ctl_in[31:16], ctl_in[7:2]};

  // Bit position of the current/next bit, derived from the remaining-bit count.
  assign w_cur_idx = IW'(r_msb ? (r_bitcnt - 1'b1) : (r_len - r_bitcnt));
  assign w_nxt_idx = IW'(r_msb ? (r_bitcnt - LW'(2)) : (r_len - r_bitcnt + 1'b1));

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      w_tx_in[k] = tx_words[k*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_go_pending) w_state_nxt = S_LOAD;
      S_LOAD:     w_state_nxt = S_SHIFT_LO;
      S_SHIFT_LO: if (w_div_end) w_state_nxt = S_SHIFT_HI;
      S_SHIFT_HI: if (w_div_end) w_state_nxt = (r_bitcnt == LW'(1)) ? S_LATCH : S_SHIFT_LO;
      S_LATCH:    if (w_div_end) w_state_nxt = S_DONE;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_go_seen  <= ctl_in[0];
      r_done_tgl <= ctl_in[0];
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_msb      <= 1'b0;
      r_count    <= 8'd0;
      r_len      <= '0;
      r_bitcnt   <= '0;
      r_div      <= '0;
      r_sclk     <= 1'b0;
      r_latch    <= 1'b0;
      r_dout     <= '0;
      r_rx_words <= '0;
      for (int k = 0; k < N_OUT; k++) r_tx[k] <= '0;
      for (int j = 0; j < N_IN; j++)  r_rx[j] <= '0;
    end else begin
      r_sclk  <= (w_state_nxt == S_SHIFT_HI);
      r_latch <= (w_state_nxt == S_LATCH);
      if (w_state_nxt != r_state) r_div <= '0;
      else if (r_state == S_SHIFT_LO || r_state == S_SHIFT_HI || r_state == S_LATCH)
        r_div <= r_div + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_go_pending) begin
            r_go_seen <= ctl_in[0];
            r_busy    <= 1'b1;
            r_overrun <= 1'b0;
            r_msb     <= ctl_in[1];
            r_len     <= w_len_eff;
            r_bitcnt  <= w_len_eff;
          end
        end
        S_LOAD: begin
          for (int k = 0; k < N_OUT; k++) begin
            r_tx[k]   <= w_tx_in[k];
            r_dout[k] <= w_tx_in[k][w_cur_idx];
          end
          for (int j = 0; j < N_IN; j++) r_rx[j] <= '0;
        end
        S_SHIFT_LO: begin
          // This edge enters SHIFT_HI, so ser_din is captured here.
          if (w_div_end) begin
            for (int j = 0; j < N_IN; j++) r_rx[j][w_cur_idx] <= ser_din[j];
          end
        end
        S_SHIFT_HI: begin
          if (w_div_end) begin
            r_bitcnt <= r_bitcnt - 1'b1;
            if (r_bitcnt != LW'(1)) begin
              for (int k = 0; k < N_OUT; k++) r_dout[k] <= r_tx[k][w_nxt_idx];
            end
          end
        end
        S_DONE: begin
          for (int j = 0; j < N_IN; j++) r_rx_words[j*WORD_W +: WORD_W] <= r_rx[j];
          r_done_tgl <= r_go_seen;
          r_busy     <= 1'b0;
          r_count    <= r_count + 8'd1;
          r_dout     <= '0;
        end
        default: ;
      endcase

      // go_seen is left alone so the pending toggle starts a transfer once idle.
      if (r_state != S_IDLE && w_go_pending) r_overrun <= 1'b1;
    end
  end

  assign status_out = {16'h0, r_count, 5'h0, r_overrun, r_busy, r_done_tgl};
  assign rx_words   = r_rx_words;
  assign ser_sclk   = r_sclk;
  assign ser_latch  = r_latch;
  assign ser_dout   = r_dout;
endmodule
